// File: rtl/pps_seconds_counter.sv
// UTC-seconds counter: synchronises 1PPS, windows it against nominal, flywheels missing pulses, applies presets.
// Pin-to-edge is 3 cycles; outputs update the cycle after a boundary. There is no backpressure (free-running).
module pps_seconds_counter #(
  parameter int unsigned CLK_HZ = 256000000,
  parameter int unsigned TOL    = 1024
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic        pps_in,
  input  logic        arm_load,
  input  logic [31:0] load_value,
  output logic [31:0] seconds,
  output logic [31:0] subsec,
  output logic        pps_pulse,
  output logic        pps_lock,
  output logic [15:0] fault_cnt
);

  localparam logic [31:0] NOM_END = 32'(CLK_HZ - 1);
  localparam logic [31:0] WIN_LO  = 32'(CLK_HZ - 1 - TOL);
  localparam logic [31:0] WIN_HI  = 32'(CLK_HZ - 1 + TOL);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FLYWHEEL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        pps_meta_q, pps_sync_q, pps_dly_q, pps_edge_q;
  logic        arm_prev_q, armed_q;
  logic [31:0] seconds_q, subsec_q;
  logic        pulse_q, lock_q;
  logic [15:0] fault_q;
  logic        arm_rise, early, in_win;
  logic        bnd_d, fault_d;

  assign arm_rise = arm_load & ~arm_prev_q;
  assign early    = subsec_q < WIN_LO;
  assign in_win   = !early && (subsec_q <= WIN_HI);

  // A real edge always wins over a synthetic boundary falling in the same cycle.
  always_comb begin
    state_d = state_q;
    bnd_d   = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (pps_edge_q) begin
          bnd_d = 1'b1;
          if (in_win) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (pps_edge_q) begin
          if (in_win) bnd_d = 1'b1;
          else        fault_d = 1'b1;
        end else if (subsec_q == WIN_HI) begin
          bnd_d   = 1'b1;
          fault_d = 1'b1;
          state_d = FLYWHEEL;
        end
      end
      FLYWHEEL: begin
        if (pps_edge_q) begin
          bnd_d = 1'b1;
          if (in_win) begin
            state_d = LOCKED;
          end else begin
            fault_d = 1'b1;
            state_d = UNLOCKED;
          end
        end else if (subsec_q == NOM_END) begin
          bnd_d = 1'b1;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q    <= UNLOCKED;
      pps_meta_q <= 1'b0;
      pps_sync_q <= 1'b0;
      pps_dly_q  <= 1'b0;
      pps_edge_q <= 1'b0;
      arm_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      seconds_q  <= '0;
      subsec_q   <= '0;
      pulse_q    <= 1'b0;
      lock_q     <= 1'b0;
      fault_q    <= '0;
    end else begin
      pps_meta_q <= pps_in;
      pps_sync_q <= pps_meta_q;
      pps_dly_q  <= pps_sync_q;
      pps_edge_q <= pps_sync_q & ~pps_dly_q;
      arm_prev_q <= arm_load;
      state_q    <= state_d;
      pulse_q    <= bnd_d;
      lock_q     <= (state_d == LOCKED);
      if (fault_d && (fault_q != 16'hFFFF)) fault_q <= fault_q + 16'd1;
      if (bnd_d) begin
        seconds_q <= (armed_q | arm_rise) ? load_value : seconds_q + 32'd1;
        armed_q   <= 1'b0;
        subsec_q  <= '0;
      end else begin
        armed_q <= armed_q | arm_rise;
        if (subsec_q != 32'hFFFF_FFFF) subsec_q <= subsec_q + 32'd1;
      end
    end
  end

  assign seconds   = seconds_q;
  assign subsec    = subsec_q;
  assign pps_pulse = pulse_q;
  assign pps_lock  = lock_q;
  assign fault_cnt = fault_q;

endmodule

// File: tb/tb_pps_seconds_counter.sv
// Randomised PPS/arm stimulus checked every cycle against a reference model of the seconds-counter rules.
module tb_pps_seconds_counter;
  localparam int CLK_HZ = 1000;
  localparam int TOL    = 4;
  localparam int NOM    = CLK_HZ - 1;

  logic        clk = 1'b0;
  logic        user_rst, pps_in, arm_load;
  logic [31:0] load_value;
  logic [31:0] seconds, subsec;
  logic        pps_pulse, pps_lock;
  logic [15:0] fault_cnt;

  always #5 clk = ~clk;

  pps_seconds_counter #(.CLK_HZ(CLK_HZ), .TOL(TOL)) dut (
    .user_clk(clk), .user_rst(user_rst), .pps_in(pps_in), .arm_load(arm_load),
    .load_value(load_value), .seconds(seconds), .subsec(subsec), .pps_pulse(pps_pulse),
    .pps_lock(pps_lock), .fault_cnt(fault_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: state named by meaning, edges tracked as arrival times.
  logic [31:0] m_sec, m_sub;
  logic        m_pulse;
  logic [15:0] m_fault;
  bit          m_armed, m_pin_prev, m_arm_prev;
  string       m_mode;
  int          edge_due[$];
  int          cyc = 0;

  // Stimulus schedule
  bit          pps_on = 1'b0;
  bit          fix_load = 1'b0;
  int          next_rise = -1, pin_left = 0, jit = 0;
  int          extra_at = -1, arm_at = -1, arm_left = 0;

  task automatic model_step();
    bit e, rise, bnd, flt, in_win, early;
    if (user_rst) begin
      m_sec = 0; m_sub = 0; m_pulse = 0; m_fault = 0; m_armed = 0;
      m_mode = "unlocked"; m_pin_prev = 0; m_arm_prev = 0;
      edge_due.delete();
      return;
    end
    e = (edge_due.size() > 0) && (edge_due[0] == cyc);
    if (e) void'(edge_due.pop_front());
    if (pps_in && !m_pin_prev) edge_due.push_back(cyc + 3);
    m_pin_prev = pps_in;
    rise = arm_load && !m_arm_prev;
    m_arm_prev = arm_load;
    early  = m_sub < NOM - TOL;
    in_win = !early && (m_sub <= NOM + TOL);
    bnd = 0; flt = 0;
    if (m_mode == "unlocked") begin
      bnd = e;
      if (e && in_win) m_mode = "locked";
    end else if (m_mode == "locked") begin
      if (e) begin bnd = in_win; flt = !in_win; end
      else if (m_sub == NOM + TOL) begin bnd = 1; flt = 1; m_mode = "flywheel"; end
    end else begin
      if (e) begin
        bnd = 1;
        if (in_win) m_mode = "locked";
        else begin flt = 1; m_mode = "unlocked"; end
      end else if (m_sub == NOM) bnd = 1;
    end
    if (flt && m_fault != 16'hFFFF) m_fault++;
    m_pulse = bnd;
    if (bnd) begin
      m_sec   = (m_armed || rise) ? load_value : m_sec + 1;
      m_armed = 0;
      m_sub   = 0;
    end else begin
      m_armed = m_armed || rise;
      if (m_sub != 32'hFFFF_FFFF) m_sub++;
    end
  endtask

  task automatic drive_inputs();
    pps_in = 1'b0;
    if (pin_left > 0) begin pps_in = 1'b1; pin_left--; end
    if (cyc == next_rise) begin
      if (pps_on) begin pps_in = 1'b1; pin_left = $urandom_range(40, 2) - 1; end
      next_rise += CLK_HZ + $urandom_range(2 * jit, 0) - jit;
    end
    if (cyc == extra_at) begin pps_in = 1'b1; pin_left = 3; end
    if (cyc == arm_at) arm_left = 8;
    arm_load = (arm_left > 0);
    if (arm_left > 0) arm_left--;
    if (!fix_load) load_value = $urandom;
  endtask

  task automatic cycle();
    drive_inputs();
    model_step();
    @(posedge clk);
    #1;
    check_eq("seconds", seconds, m_sec);
    check_eq("subsec", subsec, m_sub);
    check_eq("pps_pulse", 32'(pps_pulse), 32'(m_pulse));
    check_eq("pps_lock", 32'(pps_lock), 32'(m_mode == "locked"));
    check_eq("fault_cnt", 32'(fault_cnt), 32'(m_fault));
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_sub(input int v);
    for (int i = 0; i < 3000; i++) begin
      if (m_sub == 32'(v)) return;
      cycle();
    end
    check_eq("wait_sub", subsec, 32'(v));
  endtask

  task automatic wait_pulse();
    for (int i = 0; i < 2500; i++) begin
      cycle();
      if (pps_pulse) return;
    end
    check_eq("wait_pulse", 32'(pps_pulse), 32'd1);
  endtask

  task automatic wait_locked();
    for (int i = 0; i < 5000; i++) begin
      if (m_mode == "locked") return;
      cycle();
    end
    check_eq("wait_locked", 32'(pps_lock), 32'd1);
  endtask

  initial begin
    user_rst = 1'b1; pps_in = 1'b0; arm_load = 1'b0; load_value = '0;
    run(3);
    check_eq("rst_seconds", seconds, 32'd0);
    check_eq("rst_subsec", subsec, 32'd0);
    check_eq("rst_lock", 32'(pps_lock), 32'd0);
    check_eq("rst_fault", 32'(fault_cnt), 32'd0);
    user_rst = 1'b0;

    // Nominal PPS from an arbitrary phase: first edge unlocked, second locks.
    pps_on = 1'b1;
    next_rise = cyc + $urandom_range(900, 100);
    run(3500);

    // Preset mid-second, then an arm whose edge lands on the PPS boundary cycle.
    wait_sub(400);
    arm_at = cyc + 1;
    run(2000);
    wait_sub(300);
    arm_at = next_rise + 3;
    run(1500);

    // Preset to all-ones, then wrap to zero on the following boundary.
    wait_sub(200);
    fix_load = 1'b1; load_value = 32'hFFFF_FFFF;
    arm_at = cyc + 1;
    wait_pulse();
    check_eq("preset_max", seconds, 32'hFFFF_FFFF);
    fix_load = 1'b0;
    wait_pulse();
    check_eq("wrap_zero", seconds, 32'd0);
    check_eq("wrap_pulse", 32'(pps_pulse), 32'd1);

    // Lose PPS: flywheel, then restore at the original phase.
    wait_locked();
    pps_on = 1'b0;
    run(3500);
    pps_on = 1'b1;
    run(3000);

    // Spurious mid-second edge while locked.
    wait_locked();
    wait_sub(200);
    extra_at = cyc + 300;
    run(1500);

    // Early edge outside the window, then jittered pulses inside it.
    wait_sub(100);
    next_rise -= 20;
    run(3000);
    jit = TOL - 1;
    run(5000);
    jit = 0;

    // Reset mid-second while armed: arm is lost, everything restarts.
    wait_locked();
    wait_sub(100);
    arm_at = cyc + 1;
    wait_sub(600);
    user_rst = 1'b1;
    cycle();
    user_rst = 1'b0;
    check_eq("mid_rst_seconds", seconds, 32'd0);
    check_eq("mid_rst_lock", 32'(pps_lock), 32'd0);
    run(3000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
